// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM input PIO: register map, edge-type encodings
// and the post-reset arming delay.
package pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int ARM_CYCLES = 3;

endpackage

// File: rtl/pio_in_debounce.sv
// One-bit debounce filter: q follows d only after d has differed from q for
// DEBOUNCE consecutive cycles; any cycle where they match restarts the count.
module pio_in_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= 1'b0;
         cnt <= '0;
      end else if (d == q) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
         q   <= d;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO with 2-FF synchroniser, per-bit edge capture (W1C), irq mask and
// level irq. Define PIO_DEBOUNCE_EN to insert a per-bit debounce filter after the synchroniser.
module avalon_pio_in_edge
   import pio_pkg::*;
#(
   parameter int WIDTH     = 1,
   parameter int EDGE_TYPE = 0,
   parameter int DEBOUNCE  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Bus semantics: a write takes effect on the edge where chipselect&write is high;
   // readdata is refreshed every cycle from the address presented one cycle earlier.

   logic [WIDTH-1:0] sync_s1, sync_s2, lvl, prev;
   logic [WIDTH-1:0] irq_mask, edge_capture, det, clr;
   logic [1:0]       arm_cnt;
   logic             armed, mask_we, cap_we;
   logic [31:0]      rd_mux;
   logic             unused_ok;

   assign unused_ok = &{1'b0, writedata, DEBOUNCE[0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= in_port;
         sync_s2 <= sync_s1;
      end
   end

`ifdef PIO_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      pio_in_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
         .clk   (clk),
         .reset (reset),
         .d     (sync_s2[i]),
         .q     (lvl[i])
      );
   end
`else
   assign lvl = sync_s2;
`endif

   // Detection stays off until the synchroniser has flushed its reset contents.
   assign armed   = (arm_cnt == 2'(ARM_CYCLES));
   assign mask_we = chipselect && write && (address == ADDR_IRQMASK);
   assign cap_we  = chipselect && write && (address == ADDR_EDGECAP);
   assign clr     = cap_we ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      det = '0;
      case (EDGE_TYPE)
         EDGE_RISE: det = lvl & ~prev;
         EDGE_FALL: det = ~lvl & prev;
         default:   det = lvl ^ prev;
      endcase
      if (!armed) det = '0;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux = 32'(lvl);
         ADDR_IRQMASK: rd_mux = 32'(irq_mask);
         ADDR_EDGECAP: rd_mux = 32'(edge_capture);
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev         <= '0;
         arm_cnt      <= '0;
         irq_mask     <= '0;
         edge_capture <= '0;
         irq          <= 1'b0;
         readdata     <= '0;
      end else begin
         prev <= lvl;
         if (!armed) arm_cnt <= arm_cnt + 2'd1;
         if (mask_we) irq_mask <= writedata[WIDTH-1:0];
         // A fresh edge overrides a same-cycle clear so it is never lost.
         edge_capture <= (edge_capture & ~clr) | det;
         irq          <= |(edge_capture & irq_mask);
         readdata     <= rd_mux;
      end
   end

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Bench for avalon_pio_in_edge: a rising-edge and an any-edge instance share one bus.
module tb_avalon_pio_in_edge;

   localparam int DB  = 4;
`ifdef PIO_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
   localparam logic [31:0] ARM_CAP = 32'hA;
   localparam logic [31:0] RST_CAP = 32'h8;
`else
   localparam int LAT = 3;
   localparam logic [31:0] ARM_CAP = 32'h0;
   localparam logic [31:0] RST_CAP = 32'h0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect, write;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd_r, rd_a;
   logic        irq_r, irq_a;

   logic [31:0] exp_q[$];
   logic [31:0] got, want;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   avalon_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE(DB)) dut_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
      .writedata(writedata), .in_port(in_port), .readdata(rd_r), .irq(irq_r));

   avalon_pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE(DB)) dut_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
      .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
      tick(1);
      chipselect = 1'b0; write = 1'b0; writedata = '0;
   endtask

   task automatic bus_addr(input logic [1:0] a);
      address = a; chipselect = 1'b1; write = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; in_port = 4'b1010;
      tick(3);
      checks++; if (rd_r !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", rd_r); end
      checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_r); end
      reset = 1'b0;
      tick(12 + DB);
      bus_addr(2'd0); exp_q.push_back(32'hA); tick(1);
      got = rd_r; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL data_read: got %h expected %h", got, want); end
      bus_addr(2'd3); exp_q.push_back(ARM_CAP); tick(1);
      got = rd_r; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL no_capture_after_arm: got %h expected %h", got, want); end
      bus_addr(2'd2); exp_q.push_back(32'h0); tick(1);
      got = rd_r; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL mask_reset: got %h expected %h", got, want); end
      bus_write(2'd3, 32'hF);
   endtask

   task automatic test_rise_irq;
      bus_write(2'd2, 32'hF);
      in_port = 4'b1011;
      bus_addr(2'd3);
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back((k == LAT + 1) ? 32'h1 : 32'h0);
         tick(1);
         got = rd_r; want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL rise_latency cyc %0d: got %h expected %h", k, got, want); end
         checks++; if (irq_r !== want[0]) begin errors++; $display("FAIL rise_irq cyc %0d: got %b expected %b", k, irq_r, want[0]); end
      end
      bus_write(2'd3, 32'h1);
      checks++; if (irq_r !== 1'b1) begin errors++; $display("FAIL irq_hold_one_cycle: got %b expected 1", irq_r); end
      tick(1);
      checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", irq_r); end
      in_port = 4'b0011;
      tick(LAT + 2);
      bus_addr(2'd3); exp_q.push_back(32'h0); exp_q.push_back(32'h8); tick(1);
      got = rd_r; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL rise_ignores_fall: got %h expected %h", got, want); end
      got = rd_a; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL any_sees_fall: got %h expected %h", got, want); end
      bus_write(2'd3, 32'hF);
   endtask

   task automatic test_w1c_race;
      in_port = 4'b0111;
      tick(LAT - 1);
      bus_write(2'd3, 32'h4);
      bus_addr(2'd3); exp_q.push_back(32'h4); tick(1);
      got = rd_a; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL edge_wins_w1c: got %h expected %h", got, want); end
      bus_write(2'd3, 32'h4);
      bus_addr(2'd3); exp_q.push_back(32'h0); tick(1);
      got = rd_a; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL w1c_clears: got %h expected %h", got, want); end
   endtask

   task automatic test_mask;
      bus_write(2'd2, 32'h0);
      in_port = 4'b0101;
      tick(LAT + 2);
      bus_write(2'd3, 32'hF);
      in_port = 4'b0111;
      tick(LAT + 2);
      bus_addr(2'd3); exp_q.push_back(32'h2); tick(1);
      got = rd_r; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL masked_capture: got %h expected %h", got, want); end
      checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b expected 0", irq_r); end
      bus_write(2'd2, 32'h2);
      checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL unmask_same_cycle: got %b expected 0", irq_r); end
      tick(1);
      checks++; if (irq_r !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b expected 1", irq_r); end
   endtask

   task automatic test_back_to_back;
      logic [1:0]  addrs[4];
      logic [31:0] exps[4];
      addrs = '{2'd0, 2'd1, 2'd2, 2'd3};
      exps  = '{32'h7, 32'h0, 32'h2, 32'h2};
      for (int i = 0; i < 4; i++) begin
         bus_addr(addrs[i]); exp_q.push_back(exps[i]); tick(1);
         got = rd_r; want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL b2b_addr%0d: got %h expected %h", addrs[i], got, want); end
      end
   endtask

   task automatic test_debounce;
`ifdef PIO_DEBOUNCE_EN
      bus_write(2'd3, 32'hF);
      in_port = 4'b1111; tick(3);
      in_port = 4'b0111; tick(12);
      bus_addr(2'd3); exp_q.push_back(32'h0); tick(1);
      got = rd_r; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL glitch_rejected: got %h expected %h", got, want); end
      in_port = 4'b1111;
      for (int k = 1; k <= LAT + 1; k++) begin
         exp_q.push_back((k == LAT + 1) ? 32'h8 : 32'h0);
         tick(1);
         got = rd_r; want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL debounce_latency cyc %0d: got %h expected %h", k, got, want); end
      end
      in_port = 4'b0111;
      tick(LAT + 2);
`endif
   endtask

   task automatic test_reset_mid;
      in_port = 4'b1000;
      tick(LAT + 2);
      bus_write(2'd2, 32'hF);
      bus_addr(2'd3); exp_q.push_back(32'hF); tick(1);
      got = rd_a; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL all_edges: got %h expected %h", got, want); end
      checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_before_reset: got %b expected 1", irq_a); end
      reset = 1'b1; tick(1);
      checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL mid_reset_readdata: got %h expected 0", rd_a); end
      checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b expected 0", irq_a); end
      reset = 1'b0;
      tick(12 + DB);
      bus_addr(2'd3); exp_q.push_back(RST_CAP); tick(1);
      got = rd_a; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL mid_reset_edgecap: got %h expected %h", got, want); end
      bus_addr(2'd2); exp_q.push_back(32'h0); tick(1);
      got = rd_a; want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL mid_reset_mask: got %h expected %h", got, want); end
   endtask

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write = 1'b0; writedata = '0; in_port = '0;
      tick(1);
      test_reset();
      test_rise_irq();
      test_w1c_race();
      test_mask();
      test_back_to_back();
      test_debounce();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
